// File: rtl/lcd_bus_driver.sv
// Write-only HD44780 bus-cycle generator: setup / enable pulse / hold, then an optional execution wait.
// Optional feature macro: LCD_EXEC_WAIT_EN (adds the WAIT state and the clear/home long-wait decode).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a rising istart; bus keeps last driven value
// S_SETUP | RS/DATA driven, lcd_en low, SETUP_CYC cycles
// S_PULSE | lcd_en high, PULSE_CYC cycles
// S_HOLD  | lcd_en low, bus held, HOLD_CYC cycles
// S_WAIT  | command execution time, EXEC_CYC or LONG_EXEC_CYC cycles
// S_DONE  | odone pulse for one cycle
module lcd_bus_driver #(
    parameter int SETUP_CYC     = 4,
    parameter int PULSE_CYC     = 16,
    parameter int HOLD_CYC      = 4,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] idata,
    input  logic       irs,
    input  logic       istart,
    output logic       odone,
    output logic       obusy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || EXEC_CYC < 1 ||
        LONG_EXEC_CYC < 1 || LONG_EXEC_CYC > 131072) begin : g_param_check
        $error("lcd_bus_driver: cycle parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
`ifdef LCD_EXEC_WAIT_EN
        S_WAIT,
`endif
        S_DONE
    } state_t;

    localparam logic [16:0] SETUP_LD = 17'(SETUP_CYC - 1);
    localparam logic [16:0] PULSE_LD = 17'(PULSE_CYC - 1);
    localparam logic [16:0] HOLD_LD  = 17'(HOLD_CYC - 1);
`ifdef LCD_EXEC_WAIT_EN
    localparam logic [16:0] EXEC_LD  = 17'(EXEC_CYC - 1);
    localparam logic [16:0] LONG_LD  = 17'(LONG_EXEC_CYC - 1);
`endif

    state_t      state, state_nx;
    logic [16:0] cnt, cnt_nx;
    logic        istart_r, istart_q;
    logic        launch;
`ifdef LCD_EXEC_WAIT_EN
    logic        long_q;
    logic        is_long;

    // clear (0x01) and return-home (0x02/0x03) are the slow instructions
    assign is_long = !irs && (idata[7:2] == 6'd0) && (idata[1:0] != 2'd0);
`endif

    // istart passes through one input flop before edge detection, so launch
    // takes effect on the clock after the edge that first samples it high
    assign launch = (state == S_IDLE) && istart_r && !istart_q;
    assign lcd_rw = 1'b0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (launch) begin
                    state_nx = S_SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 17'd1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nx = S_HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 17'd1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
`ifdef LCD_EXEC_WAIT_EN
                    state_nx = S_WAIT;
                    cnt_nx   = long_q ? LONG_LD : EXEC_LD;
`else
                    state_nx = S_DONE;
                    cnt_nx   = '0;
`endif
                end else begin
                    cnt_nx = cnt - 17'd1;
                end
            end
`ifdef LCD_EXEC_WAIT_EN
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 17'd1;
                end
            end
`endif
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // outputs are registered from the next state so the pins never glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            istart_r <= 1'b0;
            istart_q <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            obusy    <= 1'b0;
            odone    <= 1'b0;
`ifdef LCD_EXEC_WAIT_EN
            long_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            istart_r <= istart;
            istart_q <= istart_r;
            lcd_en   <= (state_nx == S_PULSE);
            obusy    <= (state_nx != S_IDLE);
            odone    <= (state_nx == S_DONE);
            if (launch) begin
                lcd_data <= idata;
                lcd_rs   <= irs;
`ifdef LCD_EXEC_WAIT_EN
                long_q   <= is_long;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: directed cases plus randomized writes checked
// against an arithmetic timing model (follows LCD_EXEC_WAIT_EN if it is defined).
module tb_lcd_bus_driver;

    localparam int S = 2;
    localparam int P = 3;
    localparam int H = 2;
    localparam int E = 10;
    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] idata = 8'h00;
    logic       irs = 1'b0;
    logic       istart = 1'b0;
    logic       odone, obusy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         t;
        logic [7:0] data;
        logic       rs;
    } exp_t;

    exp_t sb[$];

    lcd_bus_driver #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .EXEC_CYC(E), .LONG_EXEC_CYC(L)
    ) dut (
        .clk(clk), .rst(rst), .idata(idata), .irs(irs), .istart(istart),
        .odone(odone), .obusy(obusy), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // cycle in which odone must be high, from the edge t that first samples istart high
    function automatic int exp_done(input int t, input logic [7:0] d, input logic rs);
        int w;
        w = 0;
`ifdef LCD_EXEC_WAIT_EN
        w = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? L : E;
`endif
        return t + 1 + S + P + H + w;
    endfunction

    // monitor
    int en_first = -1;
    int en_cnt = 0;
    int last_done = -10;

    always @(negedge clk) begin
        if (!rst) begin
            en_first  = -1;
            en_cnt    = 0;
            last_done = -10;
        end else begin
            chk("lcd_rw_low", 32'(lcd_rw), 32'd0);
            if (lcd_en && !obusy) chk("en_without_busy", 32'(lcd_en), 32'd0);
            if (lcd_en) begin
                if (en_first < 0) en_first = cyc;
                en_cnt++;
            end
            if (cyc == last_done + 1) begin
                chk("busy_after_done", 32'(obusy), 32'd0);
                chk("done_one_cycle", 32'(odone), 32'd0);
            end
            if (sb.size() != 0) begin
                if (cyc == sb[0].t + 1) chk("busy_at_t1", 32'(obusy), 32'd1);
                if (obusy) begin
                    chk("lcd_data", 32'(lcd_data), 32'(sb[0].data));
                    chk("lcd_rs", 32'(lcd_rs), 32'(sb[0].rs));
                end
            end
            if (odone) begin
                chk("odone_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("odone_cycle", 32'(cyc), 32'(exp_done(e.t, e.data, e.rs)));
                    chk("en_rise_cycle", 32'(en_first), 32'(e.t + 1 + S));
                    chk("en_width", 32'(en_cnt), 32'(P));
                end
                en_first  = -1;
                en_cnt    = 0;
                last_done = cyc;
            end
        end
    end

    // raise istart at a negedge; the next posedge is T
    task automatic launch(input logic [7:0] d, input logic rs, output int t);
        @(negedge clk);
        idata  = d;
        irs    = rs;
        istart = 1'b1;
        t      = cyc + 1;
        sb.push_back('{t, d, rs});
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (odone) begin
                ok = 1'b1;
                break;
            end
        end
        chk("odone_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic rs);
        int t;
        launch(d, rs, t);
        wait_done();
        istart = 1'b0;
    endtask

    // mid-transaction idata change and a second istart edge must both be ignored
    task automatic send_glitch(input logic [7:0] d, input logic rs);
        int t;
        launch(d, rs, t);
        while (cyc != t + 3) @(negedge clk);
        idata = 8'h55;
        irs   = ~rs;
        while (cyc != t + 5) @(negedge clk);
        istart = 1'b0;
        while (cyc != t + 7) @(negedge clk);
        istart = 1'b1;
        wait_done();
        repeat (12) @(negedge clk);
        istart = 1'b0;
    endtask

    initial begin
        int t;
        logic [7:0] d;

        #1;
        chk("rst_lcd_data", 32'(lcd_data), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        chk("rst_lcd_en", 32'(lcd_en), 32'd0);
        chk("rst_odone", 32'(odone), 32'd0);
        chk("rst_obusy", 32'(obusy), 32'd0);

        // istart already high at reset release counts as an edge
        idata  = 8'h02;
        irs    = 1'b0;
        istart = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.push_back('{cyc + 1, 8'h02, 1'b0});
        wait_done();
        istart = 1'b0;

        send(8'h41, 1'b1);
        send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send_glitch(8'h41, 1'b1);

        // asynchronous reset in the middle of the enable pulse
        launch(8'h41, 1'b1, t);
        while (cyc != t + 3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_en", 32'(lcd_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_lcd_en", 32'(lcd_en), 32'd0);
        chk("async_obusy", 32'(obusy), 32'd0);
        chk("async_lcd_data", 32'(lcd_data), 32'd0);
        chk("async_lcd_rs", 32'(lcd_rs), 32'd0);
        sb.delete();
        istart = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // back-to-back pair: drop at T+19, raise at T+20
        send(8'h41, 1'b1);
        send(8'h02, 1'b0);

        for (int n = 0; n < 40; n++) begin
            d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            send(d, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Write-only HD44780 bus-cycle generator placed between the LCD sequencing logic and the character-LCD pins. It accepts one byte plus a register-select bit per start handshake. It drives the bus with setup, enable-pulse and hold timing derived from `clk`, and waits out the command's execution time. It then signals completion with a single-cycle done pulse.

## Interface
Parameters:
- `SETUP_CYC`, default 4: cycles RS/DATA are stable before `lcd_en` rises (≥1).
- `PULSE_CYC`, default 16: cycles `lcd_en` is high (≥1).
- `HOLD_CYC`, default 4: cycles RS/DATA are held after `lcd_en` falls (≥1).
- `EXEC_CYC`, default 2000: execution wait for normal commands and data (40 µs at 50 MHz; ≥1).
- `LONG_EXEC_CYC`, default 82000: execution wait for clear/home (1.64 ms at 50 MHz; ≥1, must fit 17 bits).

Ports:
- `clk` — in, 1: system clock.
- `rst` — in, 1: asynchronous, active-low reset.
- `idata` — in, 8: byte to write.
- `irs` — in, 1: 0 = instruction, 1 = data.
- `istart` — in, 1: start request; level held by the host until `odone`.
- `odone` — out, 1: one-cycle completion pulse.
- `obusy` — out, 1: transaction in progress.
- `lcd_data` — out, 8: LCD DB7..DB0.
- `lcd_rs` — out, 1: LCD register select.
- `lcd_rw` — out, 1: LCD read/write; tied 0 (write only).
- `lcd_en` — out, 1: LCD enable strobe.

## Operation
- Reset values: `lcd_data`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `odone`=0, `obusy`=0. State is IDLE, counter is 0, and the `istart` history register is 0.
- Launch:
  - Launch happens on a rising edge of `istart`, detected against a registered copy of `istart`. The launch is accepted only in IDLE.
  - An `istart` already high when reset releases counts as a rising edge on the first clock.
  - Edges outside IDLE are ignored, not queued. The host must drop `istart` and raise it again for the next transfer.
- Capture: `idata`/`irs` are registered at launch. Later changes are ignored until the next launch.
- Long wait: the long wait applies when `irs`=0 and `idata` is 0x01 (clear) or 0x02/0x03 (home). All other bytes use the normal wait.
- State machine: IDLE → SETUP → PULSE → HOLD → WAIT → DONE → IDLE.
  - SETUP: bus driven with captured RS/DATA, `lcd_en`=0, for `SETUP_CYC` cycles.
  - PULSE: `lcd_en`=1 for `PULSE_CYC` cycles.
  - HOLD: `lcd_en`=0, bus unchanged, for `HOLD_CYC` cycles.
  - WAIT: `EXEC_CYC` or `LONG_EXEC_CYC` cycles, selected at launch.
  - DONE: `odone`=1 for exactly one cycle, then IDLE.
- Counter: one shared 17-bit down-counter, loaded on each state entry with N-1. The state advances when the counter is 0.
- Bus retention: `lcd_data`/`lcd_rs` keep their last driven value after DONE until the next launch. `lcd_en` is 0 in every state except PULSE.
- `obusy`: 1 in all states except IDLE, including the DONE cycle.
- Reset mid-transaction: all outputs return to their reset values asynchronously (`lcd_en` drops immediately). The partial transfer is abandoned with no `odone`.

## Timing
- Let T be the clock edge that samples `istart`=1 with a previous value of 0, in IDLE.
- T+1: SETUP entered; `obusy`=1; `lcd_rs`/`lcd_data` valid.
- T+1+S: `lcd_en` rises. It stays high through T+S+P.
- T+1+S+P: `lcd_en` falls.
- `odone` is high in the cycle at T+1+S+P+H+E, where E is the selected wait.
- T+2+S+P+H+E: back in IDLE. This is the earliest cycle an edge seen at T' can launch.
- With default parameters and short wait, `odone` arrives at T+2025. With the long wait, at T+82025.

## Configuration
- `LCD_EXEC_WAIT_EN` defined:
  - WAIT state present, timing as above.
- Macro undefined:
  - WAIT state and long-wait decode removed; HOLD goes directly to DONE.
  - `odone` arrives at T+1+S+P+H.
  - The host is responsible for inter-command delay; `EXEC_CYC`/`LONG_EXEC_CYC` are unused.

## Test plan
Bench parameters: S=2, P=3, H=2, E=10, LONG=20; macro defined unless stated.
- Data write: `irs`=1, `idata`=0x41, `istart` rises at T.
  - `lcd_rs`=1 and `lcd_data`=0x41 from T+1.
  - `lcd_en` high exactly at T+3..T+5.
  - `odone` one cycle at T+18; `obusy` low at T+19.
- Clear: `irs`=0, `idata`=0x01 → `odone` at T+28. Control case: `irs`=1, `idata`=0x01 → `odone` at T+18.
- Ignored edges: toggle `istart` 0→1 at T+8 mid-transaction and change `idata` to 0x55 at T+4.
  - Exactly one `odone`, at T+18.
  - `lcd_data` stays 0x41 throughout.
  - `istart` held high after `odone` produces no relaunch.
- Reset mid-PULSE: assert `rst`=0 at T+4 → `lcd_en`, `obusy`, `lcd_data` go to 0 without waiting for a clock edge. No `odone` appears; the next rising `istart` after release performs a full transfer.
- Back-to-back: host drops `istart` at T+19 and raises it at T+20 → second `odone` at T+38. `lcd_rw` stays 0 throughout.
- Macro undefined: `irs`=0, `idata`=0x01 → `odone` at T+8, with no long wait.
